// File: rtl/pipeline_stage_chain.sv
// ---------------------------------------------------------------------------
// pipeline_stage_chain
//
// Parametrised chain of pipeline boundary registers (e.g. IF/ID, ID/EX,
// EX/MEM, MEM/WB). Each stage carries an NBits payload plus a valid bit.
// Per-stage stall and flush inputs let hazard logic freeze earlier stages,
// insert bubbles and squash wrong-path instructions. Two saturating debug
// counters report stall-induced bubbles and flush cycles.
//
// Ports:
//   clk              clock, all state updates on rising edge
//   reset            synchronous active-high reset
//   in_Data          payload entering stage 0
//   in_Valid         in_Data holds a real instruction
//   in_Stall[k]      stage k must hold (also freezes every earlier stage)
//   in_Flush[k]      stage k is squashed this cycle (overrides hold)
//   out_Data         flattened stage payloads, stage k at [k*NBits +: NBits]
//   out_Valid[k]     valid bit of stage k
//   out_Ready        upstream fetch may advance (combinational from in_Stall)
//   out_BubbleCount  saturating count of stall-induced bubbles
//   out_FlushCount   saturating count of cycles with any flush bit set
// ---------------------------------------------------------------------------
module pipeline_stage_chain #(
    parameter int               NBits        = 32,
    parameter int               NUM_STAGES   = 4,
    parameter logic [NBits-1:0] BUBBLE_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NBits-1:0]            in_Data,
    input  logic                        in_Valid,
    input  logic [NUM_STAGES-1:0]       in_Stall,
    input  logic [NUM_STAGES-1:0]       in_Flush,
    output logic [NUM_STAGES*NBits-1:0] out_Data,
    output logic [NUM_STAGES-1:0]       out_Valid,
    output logic                        out_Ready,
    output logic [15:0]                 out_BubbleCount,
    output logic [15:0]                 out_FlushCount
);

    localparam int CW = $clog2(NUM_STAGES + 1);

    logic [NBits-1:0]      data_q  [NUM_STAGES];
    logic [NBits-1:0]      data_d  [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] bubble;
    logic [CW-1:0]         bubble_cnt;
    logic [15:0]           bub_cnt_q, bub_cnt_d;
    logic [15:0]           flush_cnt_q, flush_cnt_d;
    logic [16:0]           bub_sum;

    // A stall at any later stage freezes this one too, so hold_k is the
    // OR of the stall bits from k up to the last stage.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign hold[gi] = |in_Stall[NUM_STAGES-1:gi];
            assign out_Data[gi*NBits +: NBits] = data_q[gi];
        end
    endgenerate

    assign out_Valid = valid_q;
    assign out_Ready = ~hold[0];

    always_comb begin
        // Stage 0: fed from upstream, never receives a stall bubble.
        data_d[0]  = data_q[0];
        valid_d[0] = valid_q[0];
        bubble[0]  = 1'b0;
        if (in_Flush[0]) begin
            data_d[0]  = BUBBLE_VALUE;
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            data_d[0]  = in_Data;
            valid_d[0] = in_Valid;
        end

        for (int k = 1; k < NUM_STAGES; k++) begin
            data_d[k]  = data_q[k];
            valid_d[k] = valid_q[k];
            bubble[k]  = 1'b0;
            if (in_Flush[k]) begin
                data_d[k]  = BUBBLE_VALUE;
                valid_d[k] = 1'b0;
            end else if (hold[k]) begin
                data_d[k]  = data_q[k];
                valid_d[k] = valid_q[k];
            end else if (hold[k-1]) begin
                // Predecessor frozen but this stage moves on: insert bubble.
                data_d[k]  = BUBBLE_VALUE;
                valid_d[k] = 1'b0;
                bubble[k]  = 1'b1;
            end else begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    always_comb begin
        bubble_cnt = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            bubble_cnt = bubble_cnt + CW'(bubble[k]);
        end
    end

    // Saturating counters: the 17-bit sum exposes the overflow directly.
    assign bub_sum   = {1'b0, bub_cnt_q} + 17'(bubble_cnt);
    assign bub_cnt_d = bub_sum[16] ? 16'hFFFF : bub_sum[15:0];

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if ((|in_Flush) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                data_q[k] <= BUBBLE_VALUE;
            end
            valid_q     <= '0;
            bub_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q     <= valid_d;
            bub_cnt_q   <= bub_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_BubbleCount = bub_cnt_q;
    assign out_FlushCount  = flush_cnt_q;

endmodule
